// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encodings and default path width shared by the memory port arbiter.
package mem_arb_pkg;
  localparam int DEF_WIDTH = 32;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY0 = 2'b01,
    ST_BUSY1 = 2'b10
  } state_t;
endpackage

// File: rtl/mux2_w.sv
// mux2_w: parameterised 2:1 mux, z = s ? b : a.
module mux2_w #(
  parameter int WIDTH = 32
) (
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] z
);
  assign z = s ? b : a;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter/sequencer driving the shared memory port mux.
// ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise requester 0 wins ties.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             we0,
  input  logic             we1,
  input  logic             mem_ready,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic             sel,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1
);
  state_t state, state_nx;
  logic sel_nx, win, ack0_nx, ack1_nx, we_sel;
  assign ack0_nx = state == ST_BUSY0 && mem_ready;
  assign ack1_nx = state == ST_BUSY1 && mem_ready;
`ifdef ARB_ROUND_ROBIN_EN
  logic ptr;
  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= 1'b1;
    else if (ack0_nx || ack1_nx) ptr <= ack1_nx;
  end
  // on a tie the requester not served last wins
  assign win = (req0 && req1) ? ~ptr : ~req0;
`else
  assign win = ~req0;
`endif
  always_comb begin
    state_nx = state;
    sel_nx = sel;
    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_nx = win ? ST_BUSY1 : ST_BUSY0;
          sel_nx = win;
        end
      end
      ST_BUSY0, ST_BUSY1: state_nx = mem_ready ? ST_IDLE : state;
      default: state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
    end else begin
      state <= state_nx;
      sel <= sel_nx;
      ack0 <= ack0_nx;
      ack1 <= ack1_nx;
    end
  end
  assign gnt0 = state == ST_BUSY0;
  assign gnt1 = state == ST_BUSY1;
  assign mem_valid = gnt0 || gnt1;
  assign mem_we = we_sel & mem_valid;
  mux2_w #(.WIDTH(WIDTH)) u_addr (.s(sel), .a(addr0), .b(addr1), .z(mem_addr));
  mux2_w #(.WIDTH(WIDTH)) u_wdata (.s(sel), .a(wdata0), .b(wdata1), .z(mem_wdata));
  mux2_w #(.WIDTH(1)) u_we (.s(sel), .a(we0), .b(we1), .z(we_sel));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;
  localparam int W = DEF_WIDTH;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, mem_ready = 1'b0;
  logic [W-1:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic mem_valid, mem_we, sel, gnt0, gnt1, ack0, ack1;
  logic [W-1:0] mem_addr, mem_wdata;
  logic [6:0] o;
  int vectors = 0, miscompares = 0;

  mem_port_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1), .mem_ready(mem_ready), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .sel(sel),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1)
  );

  always #5 clk = ~clk;
  // observed control bundle: {mem_valid, gnt0, gnt1, ack0, ack1, sel, mem_we}
  assign o = {mem_valid, gnt0, gnt1, ack0, ack1, sel, mem_we};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; mem_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 32'hA0; addr1 = 32'hB0; mem_ready = 1'b1;
    repeat (2) begin
      tick();
      vectors++;
      if (o !== 7'b0 || mem_addr !== 32'hA0) begin
        miscompares++;
        $display("FAIL reset: ctl=%b addr=%h, required ctl=0000000 addr=000000a0", o, mem_addr);
      end
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (o !== 7'b1100000 || mem_addr !== 32'hA0) begin
      miscompares++;
      $display("FAIL first_grant: ctl=%b addr=%h, required ctl=1100000 addr=000000a0", o, mem_addr);
    end
    do_reset();
  endtask

  task automatic test_single_write;
    req0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF; we0 = 1'b1; mem_ready = 1'b1;
    tick();
    vectors++;
    if (o !== 7'b1100001 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL single_write_busy: ctl=%b addr=%h data=%h, required ctl=1100001 addr=00000010 data=deadbeef", o, mem_addr, mem_wdata);
    end
    tick();
    vectors++;
    if (o !== 7'b0001000) begin
      miscompares++;
      $display("FAIL single_write_ack: ctl=%b, required 0001000", o);
    end
    req0 = 1'b0;
    tick();
    vectors++;
    if (o !== 7'b0000000) begin
      miscompares++;
      $display("FAIL single_write_idle: ctl=%b, required 0000000", o);
    end
    do_reset();
  endtask

  task automatic test_tie;
    logic [6:0] eo [8];
    logic [W-1:0] ea [8];
    if (RR) begin
      eo = '{7'b1100000, 7'b0001000, 7'b1010010, 7'b0000110, 7'b1100000, 7'b0001000, 7'b1010010, 7'b0000110};
      ea = '{32'h100, 32'h100, 32'h200, 32'h200, 32'h100, 32'h100, 32'h200, 32'h200};
    end else begin
      eo = '{7'b1100000, 7'b0001000, 7'b1100000, 7'b0001000, 7'b1100000, 7'b0001000, 7'b1100000, 7'b0001000};
      ea = '{default: 32'h100};
    end
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'h100; addr1 = 32'h200; we0 = 1'b0; we1 = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (o !== eo[i] || mem_addr !== ea[i]) begin
        miscompares++;
        $display("FAIL tie[%0d]: ctl=%b addr=%h, required ctl=%b addr=%h", i, o, mem_addr, eo[i], ea[i]);
      end
    end
    req0 = 1'b0;
    tick();
    vectors++;
    if (o !== 7'b1010010 || mem_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL tie_release: ctl=%b addr=%h, required ctl=1010010 addr=00000200", o, mem_addr);
    end
    do_reset();
  endtask

  task automatic test_wait_states;
    req0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h1234; we0 = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin req1 = 1'b1; addr1 = 32'h50; we1 = 1'b0; end
      if (i == 3) mem_ready = 1'b1;
      vectors++;
      if (o !== 7'b1100001 || mem_addr !== 32'h40) begin
        miscompares++;
        $display("FAIL wait_hold[%0d]: ctl=%b addr=%h, required ctl=1100001 addr=00000040", i, o, mem_addr);
      end
    end
    tick();
    vectors++;
    if (o !== 7'b0001000) begin
      miscompares++;
      $display("FAIL wait_ack: ctl=%b, required 0001000", o);
    end
    req0 = 1'b0;
    tick();
    vectors++;
    if (o !== 7'b1010010 || mem_addr !== 32'h50) begin
      miscompares++;
      $display("FAIL wait_next_grant: ctl=%b addr=%h, required ctl=1010010 addr=00000050", o, mem_addr);
    end
    do_reset();
  endtask

  task automatic test_reset_mid;
    req1 = 1'b1; addr1 = 32'h77; addr0 = 32'h33; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (o !== 7'b1010010) begin
        miscompares++;
        $display("FAIL mid_busy[%0d]: ctl=%b, required 1010010", i, o);
      end
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; req1 = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (o !== 7'b0000000 || mem_addr !== 32'h33) begin
        miscompares++;
        $display("FAIL mid_reset[%0d]: ctl=%b addr=%h, required ctl=0000000 addr=00000033", i, o, mem_addr);
      end
      tick();
    end
    do_reset();
  endtask

  task automatic test_random;
    int owner = -1, ack = -1, last = 1;
    logic msel = 1'b0;
    logic [6:0] eo;
    logic [W-1:0] ea, ed;
    for (int i = 0; i < 600; i++) begin
      if (ack == 0) req0 = ($urandom_range(2) == 0);
      else if (!req0 && $urandom_range(3) == 0) begin
        req0 = 1'b1; addr0 = $urandom; wdata0 = $urandom; we0 = 1'($urandom_range(1));
      end
      if (ack == 1) req1 = ($urandom_range(2) == 0);
      else if (!req1 && $urandom_range(3) == 0) begin
        req1 = 1'b1; addr1 = $urandom; wdata1 = $urandom; we1 = 1'($urandom_range(1));
      end
      mem_ready = ($urandom_range(2) != 0);
      rst_n = ($urandom_range(60) != 0);
      if (!rst_n) begin
        owner = -1; ack = -1; last = 1; msel = 1'b0;
      end else if (owner >= 0) begin
        ack = mem_ready ? owner : -1;
        if (mem_ready) begin last = owner; owner = -1; end
      end else begin
        ack = -1;
        if (req0 || req1) begin
          owner = (req0 && req1) ? (RR ? 1 - last : 0) : (req0 ? 0 : 1);
          msel = (owner == 1);
        end
      end
      tick();
      ea = msel ? addr1 : addr0;
      ed = msel ? wdata1 : wdata0;
      eo = {owner >= 0, owner == 0, owner == 1, ack == 0, ack == 1, msel, owner >= 0 && (msel ? we1 : we0)};
      vectors++;
      if ({o, mem_addr, mem_wdata} !== {eo, ea, ed}) begin
        miscompares++;
        $display("FAIL random[%0d]: ctl=%b addr=%h data=%h, required ctl=%b addr=%h data=%h", i, o, mem_addr, mem_wdata, eo, ea, ed);
      end
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_tie();
    test_wait_states();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
